// File: rtl/fpu_host_link.sv
// Host-side link to the 10-bit FPU chip: serializes A/B/OP beats onto the
// chip pins, then waits for the done edge (or a timeout) and returns the result.
module fpu_host_link #(
    parameter int BEAT_HOLD      = 1,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [9:0]  req_a,
    input  logic [9:0]  req_b,
    input  logic [3:0]  req_op,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [9:0]  rsp_result,
    output logic        rsp_timeout,
    output logic [11:0] chip_in,
    input  logic [11:0] chip_out,
    output logic        busy
);

    localparam int BW = (BEAT_HOLD > 1) ? $clog2(BEAT_HOLD) : 1;
    localparam int WW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [BW-1:0] BEAT_LAST = BW'(BEAT_HOLD - 1);
    localparam logic [WW-1:0] WAIT_LAST = WW'(TIMEOUT_CYCLES);

    localparam logic [1:0] CODE_A  = 2'b01;
    localparam logic [1:0] CODE_B  = 2'b10;
    localparam logic [1:0] CODE_OP = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SEND_A,
        S_SEND_B,
        S_SEND_OP,
        S_WAIT,
        S_RESP
    } state_t;

    state_t         r_state;
    logic [BW-1:0]  r_beat;
    logic [WW-1:0]  r_wait;
    logic           r_done_prev;
    logic [9:0]     r_b;
    logic [3:0]     r_op;
    logic [11:0]    r_chip_in;
    logic [9:0]     r_result;
    logic           r_timeout;

    state_t         w_state_nxt;
    logic [BW-1:0]  w_beat_nxt;
    logic [WW-1:0]  w_wait_nxt;
    logic [WW-1:0]  w_wait_inc;
    logic [9:0]     w_b_nxt;
    logic [3:0]     w_op_nxt;
    logic [11:0]    w_chip_in_nxt;
    logic [9:0]     w_result_nxt;
    logic           w_timeout_nxt;
    logic           w_beat_end;
    logic           w_done_edge;
    logic           w_unused;

    assign w_unused    = chip_out[1];
    assign w_beat_end  = (r_beat == BEAT_LAST);
    assign w_done_edge = chip_out[0] && !r_done_prev;
    assign w_wait_inc  = r_wait + 1'b1;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_beat      <= '0;
            r_wait      <= '0;
            r_done_prev <= 1'b0;
            r_b         <= '0;
            r_op        <= '0;
            r_chip_in   <= '0;
            r_result    <= '0;
            r_timeout   <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_beat      <= w_beat_nxt;
            r_wait      <= w_wait_nxt;
            r_done_prev <= chip_out[0];
            r_b         <= w_b_nxt;
            r_op        <= w_op_nxt;
            r_chip_in   <= w_chip_in_nxt;
            r_result    <= w_result_nxt;
            r_timeout   <= w_timeout_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_beat_nxt    = r_beat;
        w_wait_nxt    = r_wait;
        w_b_nxt       = r_b;
        w_op_nxt      = r_op;
        w_chip_in_nxt = r_chip_in;
        w_result_nxt  = r_result;
        w_timeout_nxt = r_timeout;

        unique case (r_state)
            S_IDLE: begin
                w_chip_in_nxt = '0;
                if (req_valid) begin
                    // A payload lives in the chip_in register itself
                    w_state_nxt   = S_SEND_A;
                    w_beat_nxt    = '0;
                    w_b_nxt       = req_b;
                    w_op_nxt      = req_op;
                    w_chip_in_nxt = {req_a, CODE_A};
                end
            end
            S_SEND_A: begin
                if (w_beat_end) begin
                    w_state_nxt   = S_SEND_B;
                    w_beat_nxt    = '0;
                    w_chip_in_nxt = {r_b, CODE_B};
                end else begin
                    w_beat_nxt = r_beat + 1'b1;
                end
            end
            S_SEND_B: begin
                if (w_beat_end) begin
                    w_state_nxt   = S_SEND_OP;
                    w_beat_nxt    = '0;
                    w_chip_in_nxt = {6'b0, r_op, CODE_OP};
                end else begin
                    w_beat_nxt = r_beat + 1'b1;
                end
            end
            S_SEND_OP: begin
                if (w_beat_end) begin
                    w_state_nxt   = S_WAIT;
                    w_beat_nxt    = '0;
                    w_wait_nxt    = '0;
                    w_chip_in_nxt = '0;
                end else begin
                    w_beat_nxt = r_beat + 1'b1;
                end
            end
            S_WAIT: begin
                w_chip_in_nxt = '0;
                if (w_done_edge) begin
                    w_state_nxt   = S_RESP;
                    w_result_nxt  = chip_out[11:2];
                    w_timeout_nxt = 1'b0;
                end else if (w_wait_inc == WAIT_LAST) begin
                    w_state_nxt   = S_RESP;
                    w_result_nxt  = '0;
                    w_timeout_nxt = 1'b1;
                end else begin
                    w_wait_nxt = w_wait_inc;
                end
            end
            S_RESP: begin
                w_chip_in_nxt = '0;
                if (rsp_ready) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt   = S_IDLE;
                w_chip_in_nxt = '0;
            end
        endcase
    end

    // Outputs are forced quiet while reset is held, whatever the state
    assign req_ready   = !reset && (r_state == S_IDLE);
    assign busy        = !reset && (r_state != S_IDLE);
    assign rsp_valid   = !reset && (r_state == S_RESP);
    assign rsp_result  = reset ? 10'd0 : r_result;
    assign rsp_timeout = !reset && r_timeout;
    assign chip_in     = reset ? 12'd0 : r_chip_in;

endmodule

// File: tb/tb_fpu_host_link.sv
// Scoreboard bench for fpu_host_link: behavioural chip model, directed
// timing checks, and a randomized back-to-back run.
module tb_fpu_host_link;

    localparam int TMO = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic        reset;
    logic        req_valid, req_ready, rsp_valid, rsp_ready, rsp_timeout, busy;
    logic [9:0]  req_a, req_b, rsp_result;
    logic [3:0]  req_op;
    logic [11:0] chip_in, chip_out;

    logic        req_valid3, req_ready3, rsp_valid3, rsp_ready3, rsp_timeout3, busy3;
    logic [9:0]  req_a3, req_b3, rsp_result3;
    logic [3:0]  req_op3;
    logic [11:0] chip_in3, chip_out3;

    logic [9:0]  drv_res;
    logic        drv_done, stuck;
    logic        rr_force, rr_rand, rand_mode;

    assign chip_out  = {drv_res, 1'b0, drv_done | stuck};
    assign rsp_ready = rand_mode ? rr_rand : rr_force;
    assign chip_out3 = 12'd0;

    fpu_host_link #(.BEAT_HOLD(1), .TIMEOUT_CYCLES(TMO)) u_h1 (
        .clock(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_op(req_op),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_result(rsp_result), .rsp_timeout(rsp_timeout),
        .chip_in(chip_in), .chip_out(chip_out), .busy(busy)
    );

    fpu_host_link #(.BEAT_HOLD(3), .TIMEOUT_CYCLES(TMO)) u_h3 (
        .clock(clk), .reset(reset),
        .req_valid(req_valid3), .req_ready(req_ready3),
        .req_a(req_a3), .req_b(req_b3), .req_op(req_op3),
        .rsp_valid(rsp_valid3), .rsp_ready(rsp_ready3),
        .rsp_result(rsp_result3), .rsp_timeout(rsp_timeout3),
        .chip_in(chip_in3), .chip_out(chip_out3), .busy(busy3)
    );

    // mode 0: chip raises done in WAIT cycle 'lat'; 1: never; 2: done stuck high
    typedef struct {
        logic [9:0] a;
        logic [9:0] b;
        logic [3:0] op;
        int         mode;
        int         lat;
        logic [9:0] res;
    } txn_t;

    typedef struct {
        logic [9:0] res;
        logic       to;
    } rsp_t;

    txn_t chip_q[$];
    rsp_t exp_q[$];

    int npass = 0;
    int ntot  = 0;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        ntot++;
        if (act === exp) npass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic fail_now(input string name, input string why);
        ntot++;
        $display("FAIL %s: %s", name, why);
    endtask

    function automatic rsp_t ref_rsp(input txn_t t);
        rsp_t r;
        if (t.mode == 0 && t.lat <= TMO) begin
            r.res = t.res;
            r.to  = 1'b0;
        end else begin
            r.res = 10'd0;
            r.to  = 1'b1;
        end
        return r;
    endfunction

    task automatic at_cycle(input int k);
        do @(negedge clk); while (cyc < k);
    endtask

    task automatic issue(input logic [9:0] a, input logic [9:0] b,
                         input logic [3:0] op, input int mode, input int lat,
                         input logic [9:0] res, input bit track,
                         output int t);
        txn_t e;
        e = '{a, b, op, mode, lat, res};
        if (track) begin
            chip_q.push_back(e);
            exp_q.push_back(ref_rsp(e));
        end
        @(posedge clk); #1;
        req_valid = 1'b1;
        req_a = a;
        req_b = b;
        req_op = op;
        t = -1;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (req_ready) begin
                t = cyc;
                break;
            end
        end
        @(posedge clk); #1;
        req_valid = 1'b0;
        req_a = 10'($urandom);
        req_b = 10'($urandom);
        req_op = 4'($urandom);
        if (t < 0) fail_now("issue", "request never accepted");
    endtask

    // Behavioural chip: collects beats, then answers after the scripted latency
    initial begin
        logic [1:0] code, pcode;
        logic [9:0] ca, cb;
        logic [3:0] cop;
        int dly, hold;
        bit pend;
        txn_t e;
        pcode = 2'b00;
        ca = '0; cb = '0; cop = '0;
        dly = 0; hold = 0; pend = 1'b0;
        drv_done = 1'b0;
        drv_res = 10'd0;
        forever begin
            @(negedge clk);
            if (reset) begin
                pcode = 2'b00;
                pend = 1'b0;
                hold = 0;
                drv_done = 1'b0;
            end else begin
                code = chip_in[1:0];
                case (code)
                    2'b01: ca = chip_in[11:2];
                    2'b10: cb = chip_in[11:2];
                    2'b11: cop = chip_in[5:2];
                    default: ;
                endcase
                if (hold > 0) begin
                    hold--;
                    if (hold == 0) drv_done = 1'b0;
                end
                if (code == 2'b00 && pcode == 2'b11) begin
                    if (chip_q.size() == 0) begin
                        fail_now("chip_start", "operation with no request");
                    end else begin
                        e = chip_q.pop_front();
                        check("chip_a", 32'(ca), 32'(e.a));
                        check("chip_b", 32'(cb), 32'(e.b));
                        check("chip_op", 32'(cop), 32'(e.op));
                        if (e.mode == 0) begin
                            pend = 1'b1;
                            dly = e.lat - 1;
                            drv_res = e.res;
                        end
                    end
                end
                if (pend) begin
                    if (dly == 0) begin
                        drv_done = 1'b1;
                        hold = 2;
                        pend = 1'b0;
                    end else begin
                        dly--;
                    end
                end
                pcode = code;
            end
        end
    end

    // Response monitor
    initial begin
        rsp_t x;
        forever begin
            @(negedge clk);
            if (!reset && rsp_valid) begin
                if (exp_q.size() == 0) begin
                    fail_now("rsp_unexpected", "response with nothing outstanding");
                end else if (rsp_ready) begin
                    x = exp_q.pop_front();
                    check("rsp_result", 32'(rsp_result), 32'(x.res));
                    check("rsp_timeout", 32'(rsp_timeout), 32'(x.to));
                end
            end
        end
    end

    initial begin
        rr_rand = 1'b1;
        forever begin
            @(posedge clk); #1;
            rr_rand = ($urandom_range(0, 3) != 0);
        end
    end

    initial begin
        int t, t3;
        bit seen;
        logic [9:0] r, a3, b3;
        logic [3:0] op3;
        logic [11:0] e3;

        reset = 1'b1;
        req_valid = 1'b0; req_a = '0; req_b = '0; req_op = '0;
        req_valid3 = 1'b0; req_a3 = '0; req_b3 = '0; req_op3 = '0;
        rsp_ready3 = 1'b1;
        rr_force = 1'b1; rand_mode = 1'b0; stuck = 1'b0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_req_ready", 32'(req_ready), 0);
        check("rst_rsp_valid", 32'(rsp_valid), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_chip_in", 32'(chip_in), 0);
        check("rst_rsp_result", 32'(rsp_result), 0);
        check("rst_rsp_timeout", 32'(rsp_timeout), 0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        check("req_ready_after_reset", 32'(req_ready), 1);

        // Basic transaction with exact pin timing
        issue(10'h155, 10'h0AA, 4'h3, 0, 3, 10'h1F0, 1'b1, t);
        at_cycle(t + 1); check("basic_beat_a", 32'(chip_in), 32'h555);
        at_cycle(t + 2); check("basic_beat_b", 32'(chip_in), 32'h2AA);
        at_cycle(t + 3); check("basic_beat_op", 32'(chip_in), 32'h00F);
        at_cycle(t + 4); check("basic_wait_pins", 32'(chip_in), 0);
        check("basic_wait_busy", 32'(busy), 1);
        at_cycle(t + 6); check("basic_no_rsp_yet", 32'(rsp_valid), 0);
        at_cycle(t + 7); check("basic_rsp_valid", 32'(rsp_valid), 1);
        check("basic_rsp_result", 32'(rsp_result), 32'h1F0);
        at_cycle(t + 8); check("basic_idle_ready", 32'(req_ready), 1);

        // BEAT_HOLD=3 instance: beat widths and WAIT entry, then a timeout
        a3 = 10'($urandom); b3 = 10'($urandom); op3 = 4'($urandom);
        @(posedge clk); #1;
        req_valid3 = 1'b1; req_a3 = a3; req_b3 = b3; req_op3 = op3;
        t3 = -1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (req_ready3) begin
                t3 = cyc;
                break;
            end
        end
        @(posedge clk); #1;
        req_valid3 = 1'b0;
        if (t3 < 0) begin
            fail_now("h3_accept", "request never accepted");
        end else begin
            for (int k = 1; k <= 9; k++) begin
                at_cycle(t3 + k);
                if (k <= 3) e3 = {a3, 2'b01};
                else if (k <= 6) e3 = {b3, 2'b10};
                else e3 = {6'b0, op3, 2'b11};
                check($sformatf("h3_beat_%0d", k), 32'(chip_in3), 32'(e3));
            end
            at_cycle(t3 + 10); check("h3_wait_pins", 32'(chip_in3), 0);
            check("h3_wait_busy", 32'(busy3), 1);
            at_cycle(t3 + 17); check("h3_no_rsp_yet", 32'(rsp_valid3), 0);
            at_cycle(t3 + 18); check("h3_rsp_valid", 32'(rsp_valid3), 1);
            check("h3_rsp_timeout", 32'(rsp_timeout3), 1);
            check("h3_rsp_result", 32'(rsp_result3), 0);
        end

        // Backpressure on the response port
        rr_force = 1'b0;
        r = 10'($urandom);
        issue(10'($urandom), 10'($urandom), 4'($urandom), 0, 2, r, 1'b1, t);
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            seen = rsp_valid;
        end
        if (!seen) fail_now("bp_rsp", "no response within bound");
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_valid_hold", 32'(rsp_valid), 1);
            check("bp_result_hold", 32'(rsp_result), 32'(r));
            check("bp_req_ready_low", 32'(req_ready), 0);
        end
        @(posedge clk); #1;
        rr_force = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("bp_release_ready", 32'(req_ready), 1);
        check("bp_release_valid", 32'(rsp_valid), 0);

        // Timeout with done never raised
        issue(10'($urandom), 10'($urandom), 4'($urandom), 1, 0, 10'd0, 1'b1, t);
        at_cycle(t + 11); check("to_no_rsp_yet", 32'(rsp_valid), 0);
        at_cycle(t + 12); check("to_rsp_valid", 32'(rsp_valid), 1);
        check("to_rsp_flag", 32'(rsp_timeout), 1);

        // Timeout with done stuck high since before WAIT
        issue(10'($urandom), 10'($urandom), 4'($urandom), 2, 0, 10'd0, 1'b1, t);
        stuck = 1'b1;
        at_cycle(t + 11); check("stuck_no_rsp_yet", 32'(rsp_valid), 0);
        at_cycle(t + 12); check("stuck_rsp_valid", 32'(rsp_valid), 1);
        check("stuck_rsp_flag", 32'(rsp_timeout), 1);
        at_cycle(t + 14);
        stuck = 1'b0;

        // Reset while SEND_B is on the pins
        issue(10'($urandom), 10'($urandom), 4'($urandom), 0, 1, 10'd0, 1'b0, t);
        @(posedge clk); #1;
        reset = 1'b1;
        @(negedge clk);
        check("rstmid_chip_in", 32'(chip_in), 0);
        check("rstmid_busy", 32'(busy), 0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        check("rstmid_after_chip_in", 32'(chip_in), 0);
        check("rstmid_after_ready", 32'(req_ready), 1);
        repeat (15) @(negedge clk);
        r = 10'($urandom);
        issue(10'($urandom), 10'($urandom), 4'($urandom), 0, 4, r, 1'b1, t);

        // Randomized back-to-back traffic
        rand_mode = 1'b1;
        for (int n = 0; n < 20; n++) begin
            repeat ($urandom_range(0, 2)) @(posedge clk);
            issue(10'($urandom), 10'($urandom), 4'($urandom), 0,
                  $urandom_range(1, 10), 10'($urandom), 1'b1, t);
        end
        for (int i = 0; i < 500 && exp_q.size() != 0; i++) @(negedge clk);
        check("drain_responses", 32'(exp_q.size()), 0);
        check("drain_chip_ops", 32'(chip_q.size()), 0);
        rand_mode = 1'b0;

        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end

endmodule

// File: doc/fpu_host_link.md
# fpu_host_link

Host-side transmitter/receiver for the 10-bit FPU chip's 12-bit pin protocol. It accepts an operation (operand A, operand B, 4-bit opcode) on a valid/ready request port and serializes it onto the chip's input pins as three tagged beats. It then watches the chip's output pins for the done edge, captures the 10-bit result, and returns it on a valid/ready response port. The block lives in the test/FPGA harness and drives the chip's `io_in`; the chip's `io_out` drives this block.

## Interface
- `BEAT_HOLD`, default 1: cycles each beat is held on `chip_in`; must be ≥1.
- `TIMEOUT_CYCLES`, default 255: WAIT cycles without a done edge before the block gives up; must be ≥1.
- `clock` in 1: single clock; all state updates on its rising edge.
- `reset` in 1: synchronous and active-high.
- `req_valid` in 1: request present.
- `req_ready` out 1: block can accept a request.
- `req_a` in 10: operand A.
- `req_b` in 10: operand B.
- `req_op` in 4: opcode.
- `rsp_valid` out 1: response present.
- `rsp_ready` in 1: consumer accepts the response.
- `rsp_result` out 10: captured result.
- `rsp_timeout` out 1: response produced by timeout, not by done.
- `chip_in` out 12: drives the chip's `io_in`. Bits [11:2] carry the payload; bits [1:0] carry the beat code.
- `chip_out` in 12: from the chip's `io_out`. Bits [11:2] carry the result; bit [0] is done; bit [1] is ignored.
- `busy` out 1: high in every state except IDLE.

## Operation
- Beat codes on `chip_in[1:0]`:
  - 00: idle; payload must be 0.
  - 01: operand A.
  - 10: operand B.
  - 11: opcode, with payload = {6'b0, op}.
- States: IDLE, SEND_A, SEND_B, SEND_OP, WAIT, RESP.
- IDLE:
  - `req_ready`=1 and `chip_in`=0.
  - On `req_valid`&&`req_ready`: latch a, b, op and go to SEND_A.
- SEND_A / SEND_B / SEND_OP:
  - `chip_in` is a registered output showing the corresponding beat.
  - Each state holds for `BEAT_HOLD` cycles, tracked by a beat counter, then advances: A→B→OP→WAIT.
- WAIT:
  - `chip_in`=0.
  - A done edge is `chip_out[0]`=1 while the registered previous value of `chip_out[0]`=0. That registered value is updated every cycle, in all states.
  - On a done edge: capture `chip_out[11:2]` into `rsp_result`, set `rsp_timeout`=0, go to RESP.
  - Otherwise increment the wait counter. When the counter reaches `TIMEOUT_CYCLES`: set `rsp_result`=0 and `rsp_timeout`=1, go to RESP.
  - The wait counter is cleared on entry to WAIT. Its width is clog2(`TIMEOUT_CYCLES`+1).
  - If done is already high on entry and stays high, there is no edge, and the block times out.
- RESP:
  - `rsp_valid`=1; `rsp_result` and `rsp_timeout` are held stable.
  - On `rsp_ready`: go to IDLE.
- Latched request fields do not change while `busy`=1. `req_*` inputs are ignored outside the IDLE handshake.
- Reset:
  - Outputs while `reset`=1: `req_ready`=0, `rsp_valid`=0, `rsp_result`=0, `rsp_timeout`=0, `chip_in`=0, `busy`=0.
  - All counters and the done-history register are cleared; state goes to IDLE.
  - Reset mid-operation (any state) discards the transaction. No response is produced and `chip_in` is 0 from the next edge.

## Timing
- Request accepted at edge t, with H=`BEAT_HOLD`:
  - A beat visible in cycles t+1..t+H.
  - B beat visible in t+H+1..t+2H.
  - OP beat visible in t+2H+1..t+3H.
  - `chip_in`=0 from t+3H+1, in WAIT.
- Done edge sampled in WAIT at edge d → `rsp_valid`=1 from cycle d+1, with `rsp_result` = `chip_out[11:2]` sampled at d.
- Timeout: `rsp_valid` rises after exactly `TIMEOUT_CYCLES` WAIT cycles with no edge.
- `rsp_valid`&&`rsp_ready` at edge r → IDLE in cycle r+1, with `req_ready`=1 in that cycle. Minimum turnaround is one IDLE cycle between transactions.
- A done edge that occurs outside WAIT is ignored. No response is generated for it.
- `req_ready` is 1 only in the first cycle after reset is released and in later IDLE cycles.

## Test plan
- Basic transaction, H=1:
  - Stimulus: request a=10'h155, b=10'h0AA, op=4'h3 accepted at t.
  - Required `chip_in`: 12'h555 at t+1, 12'h2AA at t+2, 12'h00F at t+3, 0 at t+4.
  - Model chip raises done with result 10'h1F0 at t+6 → `rsp_valid` at t+7 with `rsp_result`=10'h1F0 and `rsp_timeout`=0.
- BEAT_HOLD=3: each beat is held exactly 3 cycles; WAIT is entered at t+10.
- Response backpressure: hold `rsp_ready`=0 for 5 cycles → `rsp_valid` and `rsp_result` stay stable and `req_ready` stays 0. Release → `req_ready`=1 next cycle.
- Timeout, `TIMEOUT_CYCLES`=8:
  - Chip never asserts done → `rsp_valid` after 8 WAIT cycles with `rsp_timeout`=1 and `rsp_result`=0.
  - Repeat with done stuck high from before WAIT → same timeout.
- Reset during SEND_B → `chip_in`=0 next cycle, no `rsp_valid` ever, `req_ready`=1 the cycle after reset falls. A following request then completes normally.
- Back-to-back: 20 random requests against a model chip with random 1–10 cycle latency → every response matches the model's result, in order, with no lost or duplicated responses.
